// File: rtl/fir_channel_sched.sv
// fir_channel_sched: two-channel sample scheduler for a shared fir_filter.
// Each channel latches samples into a hold register. Pending channels are
// served round-robin. A served sample is written into the channel's
// 64-entry region of the audio RAM. The filter is then armed over the
// TAPS-long window that ends at that sample, and its result is returned
// on a one-cycle out_valid strobe.
module fir_channel_sched #(
  parameter int TAPS    = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  in_valid,
  input  logic [15:0] in_data_0,
  input  logic [15:0] in_data_1,
  output logic        audio_wr_en,
  output logic [6:0]  audio_wr_addr,
  output logic [15:0] audio_wr_data,
  output logic        fir_reset,
  output logic [6:0]  fir_start_addr,
  output logic [6:0]  fir_last_addr,
  input  logic        fir_done,
  input  logic [15:0] fir_result,
  output logic        out_valid,
  output logic        out_chan,
  output logic [15:0] out_data,
  output logic [1:0]  overrun,
  output logic        timeout_err,
  input  logic        clear_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_ARM,
    S_RUN,
    S_CAPTURE
  } state_t;

  // Window start sits TAPS-1 samples behind the newest one, modulo the
  // 64-entry channel region.
  localparam logic [5:0]  TAPS_M1   = 6'(TAPS - 1);
  localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);

  state_t      state_reg;
  state_t      state_next;
  logic        chan_reg;
  logic        last_served_reg;
  logic [11:0] run_cnt_reg;
  logic        timeout_err_reg;

  logic        sel_valid;
  logic        sel_chan;
  logic        timeout_hit;

  logic        audio_wr_en_reg;
  logic [6:0]  audio_wr_addr_reg;
  logic [15:0] audio_wr_data_reg;
  logic        fir_reset_reg;
  logic [6:0]  fir_start_addr_reg;
  logic [6:0]  fir_last_addr_reg;
  logic        out_valid_reg;
  logic        out_chan_reg;
  logic [15:0] out_data_reg;

  // Per-channel views gathered from the channel slices below.
  logic [15:0] in_data_arr [2];
  logic [15:0] hold_arr    [2];
  logic [5:0]  wptr_arr    [2];
  logic [1:0]  pending_vec;
  logic [1:0]  overrun_vec;

  assign in_data_arr[0] = in_data_0;
  assign in_data_arr[1] = in_data_1;

  // wptr advances when ARM is left, for the channel being served.
  logic arm_exit;
  assign arm_exit = (state_reg == S_ARM);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [15:0] hold_reg;
      logic        pend_reg;
      logic        ovr_reg;
      logic [5:0]  wptr_reg;
      logic        sel_this;
      logic        serving_this;

      assign sel_this     = sel_valid && (sel_chan == 1'(gi));
      assign serving_this = arm_exit && (chan_reg == 1'(gi));

      // Sample capture, pending/overrun bookkeeping and write pointer for one channel.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_reg <= '0;
          pend_reg <= 1'b0;
          ovr_reg  <= 1'b0;
          wptr_reg <= '0;
        end else begin
          if (in_valid[gi]) begin
            hold_reg <= in_data_arr[gi];
          end
          // A new arrival re-arms pending even on the cycle it is selected;
          // the selected sample was already copied into the write register.
          if (in_valid[gi]) begin
            pend_reg <= 1'b1;
          end else if (sel_this) begin
            pend_reg <= 1'b0;
          end
          // Set beats clear when both happen together.
          if (in_valid[gi] && pend_reg) begin
            ovr_reg <= 1'b1;
          end else if (clear_err) begin
            ovr_reg <= 1'b0;
          end
          if (serving_this) begin
            wptr_reg <= wptr_reg + 6'd1;
          end
        end
      end

      assign hold_arr[gi]    = hold_reg;
      assign wptr_arr[gi]    = wptr_reg;
      assign pending_vec[gi] = pend_reg;
      assign overrun_vec[gi] = ovr_reg;
    end
  endgenerate

  // Next-state logic, round-robin channel selection and timeout detection.
  always_comb begin
    state_next  = state_reg;
    sel_valid   = 1'b0;
    sel_chan    = chan_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (pending_vec != 2'b00) begin
          state_next = S_WRITE;
          sel_valid  = 1'b1;
          if (pending_vec == 2'b11) begin
            sel_chan = ~last_served_reg;
          end else begin
            sel_chan = pending_vec[1];
          end
        end
      end
      S_WRITE: begin
        state_next = S_ARM;
      end
      S_ARM: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        // run_cnt_reg is the 1-based index of the current RUN cycle, so a
        // done in the first cycle is ignored.
        if ((run_cnt_reg >= 12'd2) && fir_done) begin
          state_next = S_CAPTURE;
        end else if (run_cnt_reg == TIMEOUT_C) begin
          state_next  = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register, job bookkeeping and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      chan_reg           <= 1'b0;
      last_served_reg    <= 1'b1;
      run_cnt_reg        <= '0;
      timeout_err_reg    <= 1'b0;
      audio_wr_en_reg    <= 1'b0;
      audio_wr_addr_reg  <= '0;
      audio_wr_data_reg  <= '0;
      fir_reset_reg      <= 1'b1;
      fir_start_addr_reg <= '0;
      fir_last_addr_reg  <= '0;
      out_valid_reg      <= 1'b0;
      out_chan_reg       <= 1'b0;
      out_data_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      // The filter runs only while the state is RUN.
      fir_reset_reg <= (state_next != S_RUN);

      audio_wr_en_reg <= 1'b0;
      out_valid_reg   <= 1'b0;

      // Selection loads the write port, so the WRITE cycle sees the sample
      // as it was when the channel was chosen.
      if (sel_valid) begin
        chan_reg          <= sel_chan;
        last_served_reg   <= sel_chan;
        audio_wr_en_reg   <= 1'b1;
        audio_wr_addr_reg <= {sel_chan, wptr_arr[sel_chan]};
        audio_wr_data_reg <= hold_arr[sel_chan];
      end

      // Window addresses become valid in ARM and stay put through RUN.
      if (state_reg == S_WRITE) begin
        fir_last_addr_reg  <= {chan_reg, wptr_arr[chan_reg]};
        fir_start_addr_reg <= {chan_reg, wptr_arr[chan_reg] - TAPS_M1};
      end

      if (state_reg == S_ARM) begin
        run_cnt_reg <= 12'd1;
      end else if (state_reg == S_RUN) begin
        run_cnt_reg <= run_cnt_reg + 12'd1;
      end

      if (state_reg == S_CAPTURE) begin
        out_valid_reg <= 1'b1;
        out_chan_reg  <= chan_reg;
        out_data_reg  <= fir_result;
      end

      if (timeout_hit) begin
        timeout_err_reg <= 1'b1;
      end else if (clear_err) begin
        timeout_err_reg <= 1'b0;
      end
    end
  end

  assign audio_wr_en    = audio_wr_en_reg;
  assign audio_wr_addr  = audio_wr_addr_reg;
  assign audio_wr_data  = audio_wr_data_reg;
  assign fir_reset      = fir_reset_reg;
  assign fir_start_addr = fir_start_addr_reg;
  assign fir_last_addr  = fir_last_addr_reg;
  assign out_valid      = out_valid_reg;
  assign out_chan       = out_chan_reg;
  assign out_data       = out_data_reg;
  assign overrun        = overrun_vec;
  assign timeout_err    = timeout_err_reg;
  assign busy           = (state_reg != S_IDLE);

endmodule
